// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding decode.
// Issues one outstanding 32-bit read at a time to instruction memory,
// buffers returned words in a small FIFO and presents them on the IF/ID
// register. Redirects flush buffered words and discard any in-flight
// response.
//
// state | meaning
// ------+-----------------------------------------------------------
// REQ   | no read outstanding; request pc when FIFO has room
// WAIT  | one read outstanding; next response completes it
module fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req_valid,
    output logic [63:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        stall,
    output logic [31:0] instr_reg,
    output logic [63:0] ifid_npc,
    output logic        ifid_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = 1;

    localparam logic [0:0] ST_REQ  = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]    state;
    logic [63:0]   pc;
    logic          drop;

    logic [31:0]   fifo_data [DEPTH];
    logic [63:0]   fifo_npc  [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic fifo_empty;
    logic fifo_full;
    logic req_fire;
    logic resp_take;
    logic push;
    logic pop;

    // FIFO occupancy from pointer compare; MSB distinguishes full from empty
    always_comb begin
        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    end

    // Request only from REQ (nothing pending) while the FIFO has a free slot,
    // so a returning word always has somewhere to go
    always_comb begin
        mem_req_valid = !reset && (state == ST_REQ) && !fifo_full;
        mem_req_addr  = pc;
        req_fire      = mem_req_valid && mem_req_ready;
        resp_take     = (state == ST_WAIT) && mem_resp_valid;
        push          = resp_take && !drop && !redirect_valid;
        pop           = !stall && !redirect_valid && !fifo_empty;
    end

    // Fetch control: pc, outstanding-read state and the discard flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_REQ;
            pc    <= RESET_PC & ~64'h3;
            drop  <= 1'b0;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[63:2], 2'b00};
            if (state == ST_WAIT) begin
                if (mem_resp_valid) begin
                    state <= ST_REQ;
                    drop  <= 1'b0;
                end else begin
                    drop <= 1'b1;
                end
            end else if (req_fire) begin
                // accepted at the old pc; its response must be thrown away
                state <= ST_WAIT;
                drop  <= 1'b1;
            end
        end else begin
            case (state)
                ST_REQ: begin
                    if (req_fire) begin
                        pc    <= pc + 64'd4;
                        state <= ST_WAIT;
                    end
                end
                default: begin
                    if (mem_resp_valid) begin
                        drop  <= 1'b0;
                        state <= ST_REQ;
                    end
                end
            endcase
        end
    end

    // FIFO pointers; a redirect flushes everything buffered
    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // FIFO storage; while WAITing pc already equals request address + 4
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr[AW-1:0]] <= mem_resp_data;
            fifo_npc[wr_ptr[AW-1:0]]  <= pc;
        end
    end

    // IF/ID register: pop head, bubble when empty, hold on stall
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_reg  <= NOP_INSTR;
            ifid_npc   <= 64'h0;
            ifid_valid <= 1'b0;
        end else if (redirect_valid) begin
            instr_reg  <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else if (!stall) begin
            if (!fifo_empty) begin
                instr_reg  <= fifo_data[rd_ptr[AW-1:0]];
                ifid_npc   <= fifo_npc[rd_ptr[AW-1:0]];
                ifid_valid <= 1'b1;
            end else begin
                instr_reg  <= NOP_INSTR;
                ifid_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios followed by randomized traffic,
// all checked against a transaction-level reference model with a queue.
module tb_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req_valid;
    logic [63:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        stall;
    logic [31:0] instr_reg;
    logic [63:0] ifid_npc;
    logic        ifid_valid;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (64'h0),
        .DEPTH    (DEPTH),
        .NOP_INSTR(NOP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .stall         (stall),
        .instr_reg     (instr_reg),
        .ifid_npc      (ifid_npc),
        .ifid_valid    (ifid_valid)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h0) return 32'h00500093;
        if (a == 64'h4) return 32'h00A00113;
        return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A0F0F;
    endfunction

    // reference model: architectural view of the fetch stage
    typedef struct packed {
        logic [31:0] d;
        logic [63:0] n;
    } ent_t;

    ent_t        m_q[$];
    logic [63:0] m_pc;
    logic [63:0] m_req_addr;
    logic [63:0] m_npc;
    logic [31:0] m_instr;
    bit          m_out;
    bit          m_drop;
    bit          m_valid;
    bit          primed = 0;

    // memory environment
    bit          mem_busy  = 0;
    bit          mem_stale = 0;
    bit          resp_real = 0;
    int          mem_cnt   = 0;
    int          lat_fixed = 0;
    logic [63:0] mem_addr  = 64'h0;
    bit          last_fire = 0;
    int          n_accepts = 0;

    task automatic cycle(input bit rst, input bit stl, input bit rdv,
                         input logic [63:0] rpc, input bit rdy);
        bit          pred_v;
        bit          dut_fire;
        bit          m_fire;
        bit          rsp;
        logic [63:0] dut_addr;
        ent_t        e;
        @(negedge clk);
        if (primed) begin
            check("instr_reg", instr_reg, m_instr);
            check("ifid_npc", ifid_npc, m_npc);
            check("ifid_valid", ifid_valid, m_valid);
        end
        reset          = rst;
        stall          = stl;
        redirect_valid = rdv;
        redirect_pc    = rpc;
        mem_req_ready  = rdy;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
        resp_real      = 0;
        if (!rst) begin
            if (mem_stale) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = 32'hDEADBEEF;
                mem_req_ready  = 1'b0;
                mem_stale      = 0;
            end else if (mem_busy) begin
                if (mem_cnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = mem_word(mem_addr);
                    resp_real      = 1;
                end else begin
                    mem_cnt--;
                end
            end
        end
        #1;
        pred_v = !rst && !m_out && (m_q.size() < DEPTH);
        check("mem_req_valid", {63'h0, mem_req_valid}, {63'h0, pred_v});
        if (pred_v) check("mem_req_addr", mem_req_addr, m_pc);
        dut_fire = mem_req_valid && mem_req_ready;
        dut_addr = mem_req_addr;
        m_fire   = pred_v && mem_req_ready;
        rsp      = mem_resp_valid;
        @(posedge clk);
        last_fire = dut_fire;
        if (dut_fire) n_accepts++;

        if (rst) begin
            m_q.delete();
            m_pc    = 64'h0;
            m_out   = 0;
            m_drop  = 0;
            m_instr = NOP;
            m_npc   = 64'h0;
            m_valid = 0;
            primed  = 1;
        end else if (rdv) begin
            m_q.delete();
            m_instr = NOP;
            m_valid = 0;
            m_pc    = {rpc[63:2], 2'b00};
            if (m_out) begin
                if (rsp) begin
                    m_out  = 0;
                    m_drop = 0;
                end else begin
                    m_drop = 1;
                end
            end else if (m_fire) begin
                m_out  = 1;
                m_drop = 1;
            end
        end else begin
            if (!stl) begin
                if (m_q.size() > 0) begin
                    e       = m_q.pop_front();
                    m_instr = e.d;
                    m_npc   = e.n;
                    m_valid = 1;
                end else begin
                    m_instr = NOP;
                    m_valid = 0;
                end
            end
            if (m_out) begin
                if (rsp) begin
                    if (!m_drop) begin
                        e.d = mem_word(m_req_addr);
                        e.n = m_req_addr + 64'd4;
                        m_q.push_back(e);
                    end
                    m_drop = 0;
                    m_out  = 0;
                end
            end else if (m_fire) begin
                m_req_addr = m_pc;
                m_pc       = m_pc + 64'd4;
                m_out      = 1;
            end
        end

        if (rst) begin
            if (mem_busy) mem_stale = 1;
            mem_busy = 0;
        end else begin
            if (resp_real) mem_busy = 0;
            if (dut_fire) begin
                mem_busy = 1;
                mem_addr = dut_addr;
                mem_cnt  = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 2));
            end
        end
    endtask

    initial begin
        int          acc0;
        bit          found;
        logic [63:0] rpc;
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'h0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;

        // reset, then zero-wait memory
        lat_fixed = 0;
        cycle(1, 0, 0, 64'h0, 1);
        #2;
        check("rst_instr", instr_reg, NOP);
        check("rst_valid", ifid_valid, 0);
        check("rst_npc", ifid_npc, 64'h0);
        repeat (3) cycle(0, 0, 0, 64'h0, 1);
        #2;
        check("first_instr", instr_reg, 32'h00500093);
        check("first_npc", ifid_npc, 64'h4);
        check("first_valid", ifid_valid, 1);
        found = 0;
        for (int i = 0; i < 6 && !found; i++) begin
            cycle(0, 0, 0, 64'h0, 1);
            #2;
            if (ifid_valid) found = 1;
        end
        check("second_seen", found, 1);
        check("second_instr", instr_reg, 32'h00A00113);
        check("second_npc", ifid_npc, 64'h8);

        // stall for 5 cycles: outputs hold, fetching bounded by DEPTH
        acc0 = n_accepts;
        repeat (5) cycle(0, 1, 0, 64'h0, 1);
        check("stall_accepts_le_depth", (n_accepts - acc0) <= DEPTH, 1);
        repeat (10) cycle(0, 0, 0, 64'h0, 1);

        // redirect to 0x103 while a read is outstanding
        lat_fixed = 2;
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            cycle(0, 0, 0, 64'h0, 1);
            if (last_fire) found = 1;
        end
        check("redir_wait_accept", found, 1);
        cycle(0, 0, 1, 64'h103, 1);
        #2;
        check("redir_bubble_instr", instr_reg, NOP);
        check("redir_bubble_valid", ifid_valid, 0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(0, 0, 0, 64'h0, 1);
            #2;
            if (ifid_valid) found = 1;
        end
        check("redir_valid_seen", found, 1);
        check("redir_npc", ifid_npc, 64'h104);
        check("redir_instr", instr_reg, mem_word(64'h100));

        // redirect coinciding with a response, under stall
        lat_fixed = 0;
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            cycle(0, 0, 0, 64'h0, 1);
            if (last_fire) found = 1;
        end
        check("same_cycle_accept", found, 1);
        cycle(0, 1, 1, 64'h2000, 1);
        #2;
        check("same_cycle_instr", instr_reg, NOP);
        check("same_cycle_valid", ifid_valid, 0);
        check("same_cycle_req_valid", mem_req_valid, 1);
        check("same_cycle_req_addr", mem_req_addr, 64'h2000);

        // memory not ready for 4 cycles
        repeat (4) cycle(0, 0, 0, 64'h0, 0);
        #2;
        check("not_ready_req_valid", mem_req_valid, 1);
        repeat (4) cycle(0, 0, 0, 64'h0, 1);

        // reset while WAITing with the FIFO otherwise full
        lat_fixed = 2;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle(0, 1, 0, 64'h0, 1);
            if (last_fire && m_q.size() == DEPTH - 1) found = 1;
        end
        check("full_wait_reached", found, 1);
        cycle(1, 1, 0, 64'h0, 1);
        #2;
        check("rst_wait_instr", instr_reg, NOP);
        check("rst_wait_valid", ifid_valid, 0);
        cycle(0, 0, 0, 64'h0, 1);
        #2;
        check("rst_first_req_valid", mem_req_valid, 1);
        check("rst_first_req_addr", mem_req_addr, 64'h0);
        repeat (6) cycle(0, 0, 0, 64'h0, 1);

        // randomized traffic including wrap-around redirects
        lat_fixed = -1;
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       rpc = {$urandom, $urandom};
                1:       rpc = 64'h103;
                2:       rpc = 64'hFFFF_FFFF_FFFF_FFF8 | 64'($urandom_range(0, 7));
                default: rpc = 64'($urandom_range(0, 255));
            endcase
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 11) == 0,
                  rpc,
                  $urandom_range(0, 9) < 7);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
